// File: rtl/alu_rv32.sv
// 32-bit RV32I integer ALU: combinational result and zero flag, plus a registered copy
// of both for pipelined or debug consumers.
module alu_rv32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic             en,
  output logic [WIDTH-1:0] ALURes,
  output logic             Zero,
  output logic [WIDTH-1:0] ALUResQ,
  output logic             ZeroQ
);

  localparam int unsigned ShW = $clog2(WIDTH);

  // Operation codes are {funct7[5], funct3}
  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSll  = 4'b0001,
    OpSlt  = 4'b0010,
    OpSltu = 4'b0011,
    OpXor  = 4'b0100,
    OpSrl  = 4'b0101,
    OpOr   = 4'b0110,
    OpAnd  = 4'b0111,
    OpSub  = 4'b1000,
    OpSra  = 4'b1101
  } alu_op_e;

  logic [ShW-1:0]   shamt;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;

  // Only the low log2(WIDTH) bits of B select the shift distance
  assign shamt       = B[ShW-1:0];
  assign lt_signed   = $signed(A) < $signed(B);
  assign lt_unsigned = A < B;

  // Decode the operation; unused codes produce zero
  always_comb begin
    ALURes = '0;
    case (ALUOp)
      OpAdd:   ALURes = A + B;
      OpSub:   ALURes = A - B;
      OpSll:   ALURes = A << shamt;
      OpSlt:   ALURes = {{(WIDTH-1){1'b0}}, lt_signed};
      OpSltu:  ALURes = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OpXor:   ALURes = A ^ B;
      OpSrl:   ALURes = A >> shamt;
      OpSra:   ALURes = $signed(A) >>> shamt;
      OpOr:    ALURes = A | B;
      OpAnd:   ALURes = A & B;
      default: ALURes = '0;
    endcase
  end

  assign Zero = (ALURes == '0);

  // Capture the live result and flag only when enabled, otherwise hold
  always_comb begin
    res_d  = res_q;
    zero_d = zero_q;
    if (en) begin
      res_d  = ALURes;
      zero_d = Zero;
    end
  end

  // Registered copy; the captured flag clears to 0 rather than reflecting a zero result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      zero_q <= zero_d;
    end
  end

  assign ALUResQ = res_q;
  assign ZeroQ   = zero_q;

endmodule

// File: tb/tb_alu_rv32.sv
// Self-checking bench for alu_rv32: directed and random combinational vectors plus the
// registered capture/hold/reset path, checked through a scoreboard queue.
module tb_alu_rv32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        en;
  logic [31:0] alu_res;
  logic        zero;
  logic [31:0] alu_res_q;
  logic        zero_q;

  int n_checks;
  int n_fail;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  alu_rv32 #(
    .WIDTH(32)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .A      (a),
    .B      (b),
    .ALUOp  (op),
    .en     (en),
    .ALURes (alu_res),
    .Zero   (zero),
    .ALUResQ(alu_res_q),
    .ZeroQ  (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model written independently of the RTL: bitwise shift loops, sign-bit compare
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] r;
    int          sh;
    sh = int'(y[4:0]);
    r  = x;
    case (o)
      4'b0000: r = x + y;
      4'b1000: r = x + ~y + 32'd1;
      4'b0001: for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
      4'b0101: for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
      4'b1101: for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      4'b0010: r = (x[31] != y[31]) ? {31'd0, x[31]} : {31'd0, x < y};
      4'b0011: r = {31'd0, x < y};
      4'b0100: r = x ^ y;
      4'b0110: r = x | y;
      4'b0111: r = x & y;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Pop the oldest expectation and compare against the live combinational outputs
  task automatic check_comb();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, "_res"}, alu_res, e.res);
      check_eq({e.tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
    end
  endtask

  // Pop the oldest expectation and compare against the registered outputs
  task automatic check_reg();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, "_resq"}, alu_res_q, e.res);
      check_eq({e.tag, "_zeroq"}, {31'd0, zero_q}, {31'd0, e.zero});
    end
  endtask

  task automatic apply(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res);
    exp_t e;
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    e.tag  = tag;
    e.res  = exp_res;
    e.zero = (exp_res == 32'd0);
    sb.push_back(e);
    #1;
    check_comb();
  endtask

  task automatic push_reg(input string tag, input logic [31:0] r, input logic z);
    exp_t e;
    e.tag  = tag;
    e.res  = r;
    e.zero = z;
    sb.push_back(e);
  endtask

  vec_t vecs[$];
  logic [3:0] legal_ops[10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    en  = 1'b0;
    a   = 32'd0;
    b   = 32'd0;
    op  = 4'b0000;

    // Asynchronous reset with no clock edge in between
    #2 rst = 1'b1;
    #1;
    push_reg("rst_async", 32'd0, 1'b0);
    check_reg();

    vecs = '{
      '{"add_zero",  4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
      '{"add",       4'b0000, 32'h0000_0003, 32'h0000_0005, 32'h0000_0008},
      '{"add_wrap",  4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
      '{"sub_neg",   4'b1000, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE},
      '{"sll",       4'b0001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004},
      '{"sll_mask",  4'b0001, 32'h0000_0001, 32'h0000_0022, 32'h0000_0004},
      '{"sll_zero",  4'b0001, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678},
      '{"slt_neg",   4'b0010, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001},
      '{"sltu_big",  4'b0011, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0000},
      '{"sltu",      4'b0011, 32'h0000_0002, 32'h0000_0003, 32'h0000_0001},
      '{"slt_eq",    4'b0010, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000},
      '{"sltu_eq",   4'b0011, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000},
      '{"slt_minmax",4'b0010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001},
      '{"xor",       4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00},
      '{"or",        4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0},
      '{"and",       4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0},
      '{"sra",       4'b1101, 32'hFFFF_FFF8, 32'h0000_0001, 32'hFFFF_FFFC},
      '{"srl",       4'b0101, 32'hFFFF_FFF8, 32'h0000_0001, 32'h7FFF_FFFC},
      '{"sra_31",    4'b1101, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF},
      '{"srl_31",    4'b0101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001},
      '{"srl_zero",  4'b0101, 32'h8765_4321, 32'h0000_0020, 32'h8765_4321},
      '{"ill_1111",  4'b1111, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000},
      '{"ill_1001",  4'b1001, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000},
      '{"ill_1010",  4'b1010, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000},
      '{"ill_1011",  4'b1011, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000},
      '{"ill_1100",  4'b1100, 32'h1234_5678, 32'h0000_0005, 32'h0000_0000},
      '{"ill_1110",  4'b1110, 32'h0000_0003, 32'h8000_0000, 32'h0000_0000}
    };

    // Combinational path is independent of reset, so these run with rst held high
    foreach (vecs[i]) apply(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
    check_eq("rst_hold_resq", alu_res_q, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = legal_ops[$urandom_range(9, 0)];
      ra = $urandom;
      rb = $urandom;
      apply($sformatf("rnd%0d_op%b", i, ro), ro, ra, rb, model(ro, ra, rb));
    end

    // Release reset and capture ADD 3+5
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    op  = 4'b0000;
    a   = 32'd3;
    b   = 32'd5;
    push_reg("cap_add", 32'd8, 1'b0);
    @(posedge clk);
    #1;
    check_reg();

    // Hold with en low while the live result changes
    @(negedge clk);
    en = 1'b0;
    op = 4'b1000;
    push_reg("hold_sub", 32'd8, 1'b0);
    @(posedge clk);
    #1;
    check_reg();
    check_eq("hold_live", alu_res, 32'hFFFF_FFFE);

    // Capture a zero result: ZeroQ rises
    @(negedge clk);
    en = 1'b1;
    op = 4'b1111;
    push_reg("cap_zero", 32'd0, 1'b1);
    @(posedge clk);
    #1;
    check_reg();

    // Capture 8 again, then assert reset between edges
    @(negedge clk);
    op = 4'b0000;
    push_reg("cap_add2", 32'd8, 1'b0);
    @(posedge clk);
    #1;
    check_reg();
    #2 rst = 1'b1;
    #1;
    push_reg("rst_mid", 32'd0, 1'b0);
    check_reg();

    // Reset overrides capture across an enabled edge
    @(posedge clk);
    #1;
    push_reg("rst_over_en", 32'd0, 1'b0);
    check_reg();

    // After release, no capture until en is high
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(posedge clk);
    #1;
    push_reg("post_rst_hold", 32'd0, 1'b0);
    check_reg();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    push_reg("post_rst_cap", 32'd8, 1'b0);
    check_reg();

    check_eq("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_rv32.md
Name: alu_rv32

Overview:
32-bit integer ALU for the single-cycle RV32I datapath. It evaluates the RV32I register/immediate arithmetic, logic, shift and compare operations combinationally from two 32-bit operands and a 4-bit operation code. It also provides a zero flag and a registered copy of result and flag for pipelined or debug consumers. The combinational result feeds the datapath directly (register write-back, memory address).

Parameters:
WIDTH, 32, operand/result width; shift amount uses low log2(WIDTH) bits of B (5 bits at default)

Ports:
clk  input  1  clock; registered outputs update on rising edge
rst  input  1  asynchronous, active-high reset; clears registered outputs
A  input  WIDTH  operand A (rs1), signed two's complement
B  input  WIDTH  operand B (rs2 or immediate), signed two's complement
ALUOp  input  4  operation select, encoded as {funct7[5], funct3}
en  input  1  load enable for registered outputs
ALURes  output  WIDTH  combinational result
Zero  output  1  combinational; 1 when ALURes == 0
ALUResQ  output  WIDTH  registered ALURes
ZeroQ  output  1  registered Zero

Behaviour:
- ALURes and Zero are purely combinational, independent of clk, rst and en. Output settles within the same delta/cycle as an input change.
- ALUOp decode:
  - 0000 ADD: A + B, modulo 2^32, wrap silently, no overflow output.
  - 1000 SUB: A - B, modulo 2^32.
  - 0001 SLL: A << B[4:0], zero-fill.
  - 0010 SLT: 1 if $signed(A) < $signed(B), else 0; zero-extended to 32 bits.
  - 0011 SLTU: 1 if $unsigned(A) < $unsigned(B), else 0.
  - 0100 XOR: A ^ B.
  - 0101 SRL: A >> B[4:0], logical, zero-fill.
  - 1101 SRA: A >>> B[4:0], arithmetic, sign-fill from A[31].
  - 0110 OR: A | B.
  - 0111 AND: A & B.
  - All other codes (1001, 1010, 1011, 1100, 1110, 1111): ALURes = 0, Zero = 1.
- Shifts ignore B[31:5]; a shift amount of 0 returns A unchanged.
- Compare ops with equal operands return 0.
- No latches: every output is assigned on every path.
- Registered outputs:
  - rst = 1 (asynchronous, any time): ALUResQ = 0 and ZeroQ = 0 immediately, held while rst is high.
  - Rising clk edge with rst = 0 and en = 1: ALUResQ <= ALURes, ZeroQ <= Zero (1-cycle latency).
  - en = 0: hold.
  - Reset asserted mid-operation overrides any pending capture. The first capture after deassertion occurs on the next rising edge with en = 1.
  - ZeroQ resets to 0, not 1; it is a captured flag, not a live evaluation.

Test Plan:
- ADD: A=0,B=0,op=0000 -> ALURes=0, Zero=1. A=3,B=5 -> 8, Zero=0. A=0x7FFFFFFF,B=1 -> 0x80000000 (wrap).
- SUB/SLL: A=3,B=5,op=1000 -> -2 (0xFFFFFFFE). A=1,B=2,op=0001 -> 4. A=1,B=0x22,op=0001 -> 4 (only B[4:0] used).
- Compares: A=-2,B=3,op=0010 -> 1. Same operands, op=0011 -> 0 (unsigned 0xFFFFFFFE > 3). A=2,B=3,op=0011 -> 1. A=B=7 for SLT and SLTU -> 0.
- Logic/shift-right: A=0xF0F0F0F0,B=0x0FF00FF0: XOR -> 0xFF00FF00, OR -> 0xFFF0FFF0, AND -> 0x00F000F0. A=-8,B=1: SRA -> -4, SRL -> 0x7FFFFFFC.
- Illegal op: op=1111 with A=3,B=5 -> ALURes=0, Zero=1.
- Register path:
  - rst=1 -> ALUResQ=0, ZeroQ=0 without a clock edge.
  - Release rst, en=1, A=3,B=5,ADD -> ALUResQ=8 after one rising edge.
  - en=0, change op to SUB -> ALUResQ stays 8.
  - Assert rst between edges -> ALUResQ=0 immediately.
